// File: rtl/board_rst_ctrl.sv
// Board reset sequencer: lock-gated reset release plus per-channel
// push-button synchronizing, debouncing and press detection.
module board_rst_ctrl #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic [N_BTN-1:0] btn,
    output logic             rst_out,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_press,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0]            r_lock_sync;
    logic [SYNC_STAGES-1:0][N_BTN-1:0] r_btn_sync;
    logic                              w_lock_s;
    logic [N_BTN-1:0]                  w_btn_s;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HW-1:0]    r_hold_cnt;
    logic [HW-1:0]    w_hold_cnt_nxt;
    logic             r_rst_out;

    logic [DW-1:0]    r_db_cnt [N_BTN];
    logic [N_BTN-1:0] r_btn_db;
    logic [N_BTN-1:0] r_btn_db_d;
    logic [N_BTN-1:0] r_btn_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_sync <= '0;
            r_btn_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];

    // Lock loss wins over hold completion; illegal encodings fall back.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = '0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = RUN;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_lock_s) w_state_nxt = WAIT_LOCK;
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WAIT_LOCK;
            r_hold_cnt <= '0;
            r_rst_out  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_rst_out  <= (w_state_nxt != RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
            r_btn_db <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (w_btn_s[i] == r_btn_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_btn_db[i] <= w_btn_s[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Gating on the next state keeps btn_press low whenever state != RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_db_d  <= '0;
            r_btn_press <= '0;
        end else begin
            r_btn_db_d  <= r_btn_db;
            r_btn_press <= (w_state_nxt == RUN) ?
                           (r_btn_db & ~r_btn_db_d) : '0;
        end
    end

    assign rst_out   = r_rst_out;
    assign btn_db    = r_btn_db;
    assign btn_press = r_btn_press;
    assign state     = r_state;

endmodule

// File: tb/tb_board_rst_ctrl.sv
// Directed bench for board_rst_ctrl: cycle-stamped expectations are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_board_rst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic [3:0] btn;
    logic       rst_out;
    logic [3:0] btn_db;
    logic [3:0] btn_press;
    logic [1:0] state;

    board_rst_ctrl #(
        .N_BTN(4),
        .SYNC_STAGES(2),
        .HOLD_CYCLES(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .locked(locked),
        .btn(btn),
        .rst_out(rst_out),
        .btn_db(btn_db),
        .btn_press(btn_press),
        .state(state)
    );

    always #5 clk = ~clk;

    localparam int K_ST = 0;
    localparam int K_RO = 1;
    localparam int K_DB = 2;
    localparam int K_PR = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int k, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.kind = k;
        e.val = v;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > c) begin
                q.insert(i, e);
                return;
            end
        end
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic string kname(input int k);
        case (k)
            K_ST:    return "state";
            K_RO:    return "rst_out";
            K_DB:    return "btn_db";
            default: return "btn_press";
        endcase
    endfunction

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            case (e.kind)
                K_ST:    act = {2'b00, state};
                K_RO:    act = {3'b000, rst_out};
                K_DB:    act = btn_db;
                default: act = btn_press;
            endcase
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s missed at cyc %0d (now %0d)",
                         kname(e.kind), e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s cyc %0d got %h expected %h",
                         kname(e.kind), cyc, act, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst = 1'b1;
        locked = 1'b0;
        btn = '0;

        // Reset values
        tick(1);
        expect_at(cyc, K_ST, 4'd0);
        expect_at(cyc, K_RO, 4'd1);
        expect_at(cyc, K_DB, 4'd0);
        expect_at(cyc, K_PR, 4'd0);
        rst = 1'b0;
        expect_at(cyc + 3, K_ST, 4'd0);
        tick(4);

        // Power-up sequence
        t0 = cyc;
        locked = 1'b1;
        expect_at(t0 + 2, K_ST, 4'd0);
        expect_at(t0 + 3, K_ST, 4'd1);
        expect_at(t0 + 3, K_RO, 4'd1);
        expect_at(t0 + 10, K_ST, 4'd1);
        expect_at(t0 + 10, K_RO, 4'd1);
        expect_at(t0 + 11, K_ST, 4'd2);
        expect_at(t0 + 11, K_RO, 4'd0);
        tick(13);

        // Bounce on btn[0]: 1,0,1,1,1,1 then held, released later
        t0 = cyc;
        expect_at(t0 + 4, K_PR, 4'd0);
        expect_at(t0 + 7, K_DB, 4'd0);
        expect_at(t0 + 8, K_DB, 4'b0001);
        expect_at(t0 + 8, K_PR, 4'd0);
        expect_at(t0 + 9, K_PR, 4'b0001);
        expect_at(t0 + 10, K_PR, 4'd0);
        expect_at(t0 + 15, K_DB, 4'b0001);
        expect_at(t0 + 16, K_DB, 4'd0);
        expect_at(t0 + 16, K_PR, 4'd0);
        expect_at(t0 + 17, K_PR, 4'd0);
        btn[0] = 1'b1; tick(1);
        btn[0] = 1'b0; tick(1);
        btn[0] = 1'b1; tick(8);
        btn[0] = 1'b0; tick(9);

        // btn[1] held 10 cycles, then released
        t0 = cyc;
        btn[1] = 1'b1;
        expect_at(t0 + 6, K_DB, 4'b0010);
        expect_at(t0 + 6, K_PR, 4'd0);
        expect_at(t0 + 7, K_PR, 4'b0010);
        expect_at(t0 + 8, K_PR, 4'd0);
        expect_at(t0 + 16, K_DB, 4'd0);
        expect_at(t0 + 16, K_PR, 4'd0);
        expect_at(t0 + 17, K_PR, 4'd0);
        tick(10);
        btn[1] = 1'b0;
        tick(9);

        // Simultaneous press on all channels for 6 cycles
        t0 = cyc;
        btn = 4'b1111;
        expect_at(t0 + 6, K_DB, 4'b1111);
        expect_at(t0 + 6, K_PR, 4'd0);
        expect_at(t0 + 7, K_PR, 4'b1111);
        expect_at(t0 + 8, K_PR, 4'd0);
        expect_at(t0 + 12, K_DB, 4'd0);
        tick(6);
        btn = 4'b0000;
        tick(9);

        // One-cycle lock loss in RUN
        t0 = cyc;
        locked = 1'b0;
        expect_at(t0 + 2, K_ST, 4'd2);
        expect_at(t0 + 2, K_RO, 4'd0);
        expect_at(t0 + 3, K_ST, 4'd0);
        expect_at(t0 + 3, K_RO, 4'd1);
        expect_at(t0 + 4, K_ST, 4'd1);
        expect_at(t0 + 11, K_RO, 4'd1);
        expect_at(t0 + 12, K_ST, 4'd2);
        expect_at(t0 + 12, K_RO, 4'd0);
        tick(1);
        locked = 1'b1;
        tick(13);

        // Async reset mid-RUN while btn_db = 1010 and press pending
        t0 = cyc;
        btn = 4'b1010;
        expect_at(t0 + 6, K_DB, 4'b1010);
        tick(7);
        #2;
        rst = 1'b1;
        btn = 4'b0000;
        expect_at(cyc, K_ST, 4'd0);
        expect_at(cyc, K_RO, 4'd1);
        expect_at(cyc, K_DB, 4'd0);
        expect_at(cyc, K_PR, 4'd0);
        expect_at(cyc + 1, K_ST, 4'd0);
        expect_at(cyc + 2, K_RO, 4'd1);
        tick(2);

        // Repeat power-up after reset; btn[2] pressed during HOLD
        t0 = cyc;
        rst = 1'b0;
        expect_at(t0 + 2, K_ST, 4'd0);
        expect_at(t0 + 3, K_ST, 4'd1);
        expect_at(t0 + 8, K_DB, 4'd0);
        expect_at(t0 + 9, K_DB, 4'b0100);
        expect_at(t0 + 10, K_ST, 4'd1);
        expect_at(t0 + 10, K_PR, 4'd0);
        expect_at(t0 + 10, K_RO, 4'd1);
        expect_at(t0 + 11, K_ST, 4'd2);
        expect_at(t0 + 11, K_RO, 4'd0);
        expect_at(t0 + 11, K_PR, 4'd0);
        expect_at(t0 + 12, K_PR, 4'd0);
        expect_at(t0 + 12, K_DB, 4'b0100);
        tick(3);
        btn[2] = 1'b1;
        tick(11);

        // Lock loss during HOLD restarts the full hold period
        t0 = cyc;
        locked = 1'b0;
        expect_at(t0 + 3, K_ST, 4'd0);
        expect_at(t0 + 3, K_RO, 4'd1);
        expect_at(t0 + 4, K_ST, 4'd1);
        expect_at(t0 + 8, K_ST, 4'd1);
        expect_at(t0 + 9, K_ST, 4'd0);
        expect_at(t0 + 9, K_RO, 4'd1);
        expect_at(t0 + 10, K_ST, 4'd1);
        expect_at(t0 + 10, K_RO, 4'd1);
        expect_at(t0 + 17, K_ST, 4'd1);
        expect_at(t0 + 17, K_RO, 4'd1);
        expect_at(t0 + 18, K_ST, 4'd2);
        expect_at(t0 + 18, K_RO, 4'd0);
        expect_at(t0 + 18, K_PR, 4'd0);
        tick(1);
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(15);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never checked (cyc %0d)", kname(e.kind), e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_rst_ctrl.md
BOARD_RST_CTRL -- requirements
Module: board_rst_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of push-button channels, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of every input synchronizer, minimum 2.
REQ-003 Parameter HOLD_CYCLES, default 16: cycles the reset is held after clock lock, minimum 1.
REQ-004 Parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles needed to accept a button change, minimum 2.
REQ-005 clk  input  1  single system clock (pixel clock domain); all logic SHALL be clocked on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset (board button).
REQ-007 locked  input  1  clock-generator lock flag, asynchronous to clk.
REQ-008 btn  input  N_BTN  raw, bouncing, asynchronous button levels, active-high.
REQ-009 rst_out  output  1  synchronous active-high reset for downstream logic, registered.
REQ-010 btn_db  output  N_BTN  debounced button levels, registered.
REQ-011 btn_press  output  N_BTN  one-cycle pulse per debounced rising edge, registered.
REQ-012 state  output  2  FSM state: 0 WAIT_LOCK, 1 HOLD, 2 RUN.

Function
REQ-013 locked and each btn bit SHALL pass through a SYNC_STAGES-deep synchronizer; locked_s and btn_s denote the synchronizer outputs.
REQ-014 WAIT_LOCK: rst_out=1, hold counter=0; go to HOLD on the first edge where locked_s=1.
REQ-015 HOLD: rst_out=1, hold counter increments each cycle; go to RUN on the edge where counter==HOLD_CYCLES-1 and locked_s=1.
REQ-016 HOLD with locked_s=0: return to WAIT_LOCK and clear the counter; this takes priority over completion.
REQ-017 RUN: rst_out=0; on locked_s=0, go to WAIT_LOCK with rst_out=1 on the same edge.
REQ-018 rst_out SHALL fall on the edge that enters RUN. It SHALL therefore be high for exactly HOLD_CYCLES cycles counted from HOLD entry.
REQ-019 Encoding 3 for state is unreachable and SHALL recover to WAIT_LOCK on the next edge.
REQ-020 Debounce operates per channel with an independent counter of width $clog2(DEBOUNCE_CYCLES).
  - btn_s == btn_db: counter cleared.
  - btn_s != btn_db: counter increments.
REQ-021 On the edge where btn_s != btn_db and counter == DEBOUNCE_CYCLES-1, btn_db SHALL take btn_s and the counter SHALL clear. A change is therefore accepted after exactly DEBOUNCE_CYCLES consecutive mismatching cycles.
REQ-022 Any single cycle of btn_s == btn_db during counting SHALL restart the count from 0 (glitch rejection).
REQ-023 btn_press[i] SHALL be 1 for exactly one cycle, the cycle after btn_db[i] rises, and only when state==RUN; falling edges produce no pulse.
REQ-024 Debouncers SHALL run in all FSM states; btn_press SHALL be 0 whenever state!=RUN.
REQ-025 Channels SHALL be fully independent; simultaneous changes on several channels produce simultaneous pulses.

Reset
REQ-026 rst=1 SHALL asynchronously force these values:
  - state=WAIT_LOCK, rst_out=1, btn_db=0, btn_press=0.
  - all counters=0, all synchronizer stages=0.
REQ-027 rst asserted mid-operation, in any state, SHALL apply REQ-026 immediately, with no clock edge required.
REQ-028 After rst falls, the full WAIT_LOCK -> HOLD -> RUN sequence SHALL be repeated.
REQ-029 Deassertion of rst is not required to be synchronized inside this block; it is assumed to meet recovery timing at the top level.

Verification
(Parameters for all scenarios: SYNC_STAGES=2, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4, N_BTN=4.)
REQ-030 Power-up: rst pulse, then locked rises at edge 0 -> state=1 at edge 3, rst_out=1 through edge 10, state=2 and rst_out=0 at edge 11.
REQ-031 Lock loss: locked falls for 1 cycle during HOLD -> state returns to 0, counter restarts, rst_out stays 1, full 8-cycle HOLD is repeated. In RUN, the same stimulus -> rst_out=1 two edges plus one edge after the drop.
REQ-032 Bounce: btn[0] toggles 1,0,1,1,1,1 (one value per cycle) in RUN -> btn_db[0] rises only after 4 stable synchronized cycles; exactly one btn_press[0] pulse.
REQ-033 Release and pre-RUN press: btn[1] held 10 cycles then released -> one pulse, nothing on release. btn[2] pressed during HOLD -> btn_db[2]=1 but no btn_press[2].
REQ-034 Async reset mid-RUN: rst asserted between clock edges with btn_db=4'b1010 -> outputs reach reset values before the next edge (rst_out=1, btn_db=0, state=0).
REQ-035 Simultaneous press: btn=4'b1111 stable for 6 cycles in RUN -> btn_press=4'b1111 for exactly one cycle.
